// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte-wide RAM controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnMem
  } owner_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam int unsigned RAM_W  = 8;
  localparam int unsigned WORD_W = 32;
  // Wide enough to hold the byte count 4
  localparam int unsigned CNT_W  = 3;

  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    logic [CNT_W-1:0] n;
    case (len)
      LEN_B:        n = CNT_W'(1);
      LEN_H:        n = CNT_W'(2);
      LEN_W, 2'b11: n = CNT_W'(4);
      default:      n = CNT_W'(4);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester (IF / MEM) and RAM-side signals of the memory controller.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush_if;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_stall_req;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              mem_stall_req;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  // Controller side
  modport slave (
    input  if_req, if_addr, flush_if,
    output if_data, if_done, if_stall_req,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output mem_rdata, mem_done, mem_stall_req,
    output ram_a, ram_dout, ram_wr,
    input  ram_din
  );

  // Requesters plus RAM
  modport master (
    output if_req, if_addr, flush_if,
    input  if_data, if_done, if_stall_req,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  mem_rdata, mem_done, mem_stall_req,
    input  ram_a, ram_dout, ram_wr,
    output ram_din
  );

endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: access counter, RAM address/write-byte generation and
// little-endian assembly of read bytes.
module mem_ctrl_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic              cap,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [RAM_W-1:0]  ram_din,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] ram_a,
  output logic [RAM_W-1:0]  ram_dout,
  output logic [WORD_W-1:0] rdata
);

  logic [ADDR_W-1:0] base_q;
  logic [WORD_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] data_q, data_d;
  logic [1:0]        cap_idx;

  // The byte arriving now belongs to the address issued one cycle earlier
  assign cap_idx = 2'(cnt_q - CNT_W'(1));

  always_comb begin
    data_d = data_q;
    data_d[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      base_q  <= addr;
      wdata_q <= wdata;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      if (adv) cnt_q <= cnt_q + CNT_W'(1);
      if (cap) data_q <= data_d;
    end
  end

  assign cnt      = cnt_q;
  assign ram_a    = base_q + ADDR_W'(cnt_q);
  assign ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign rdata    = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-priority, non-preemptive arbiter sharing one byte-wide RAM port
// between instruction fetch and the MEM stage.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter bit          MEM_PRIO = 1'b1
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  mem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [CNT_W-1:0]  nbytes_q;
  logic [CNT_W-1:0]  cnt;
  logic              load, adv, cap;
  logic              if_ok, grant_mem;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] ram_a;
  logic [RAM_W-1:0]  ram_dout;
  logic [WORD_W-1:0] rdata;
  logic              done, done_if, done_mem;

  // A flushed fetch is never granted
  assign if_ok     = bus.if_req && !bus.flush_if;
  assign grant_mem = bus.mem_req && (MEM_PRIO || !if_ok);
  assign req_addr  = grant_mem ? bus.mem_addr : bus.if_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= OwnIf;
      nbytes_q <= '0;
    end else if (load) begin
      owner_q  <= grant_mem ? OwnMem : OwnIf;
      nbytes_q <= grant_mem ? len_bytes(bus.mem_len) : CNT_W'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          load    = 1'b1;
          state_d = bus.mem_we ? StWr : StRd;
        end else if (if_ok) begin
          load    = 1'b1;
          state_d = StRd;
        end
      end
      StRd: begin
        if (owner_q == OwnIf && bus.flush_if) begin
          state_d = StIdle;
        end else begin
          cap = (cnt != '0);
          if (cnt == nbytes_q) state_d = StDone;
          else                 adv     = 1'b1;
        end
      end
      StWr: begin
        if (cnt == nbytes_q - CNT_W'(1)) state_d = StDone;
        else                             adv     = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Global halt: everything holds where it is
    if (!rdy) begin
      state_d = state_q;
      load    = 1'b0;
      adv     = 1'b0;
      cap     = 1'b0;
    end
  end

  always_comb begin
    done              = (state_q == StDone) && rdy;
    done_if           = done && (owner_q == OwnIf);
    done_mem          = done && (owner_q == OwnMem);
    bus.if_done       = done_if;
    bus.mem_done      = done_mem;
    bus.if_data       = done_if ? rdata : '0;
    bus.mem_rdata     = done_mem ? rdata : '0;
    bus.if_stall_req  = bus.if_req && !done_if;
    bus.mem_stall_req = bus.mem_req && !done_mem;
    bus.ram_a         = ram_a;
    bus.ram_dout      = ram_dout;
    bus.ram_wr        = (state_q == StWr) && rdy;
  end

  mem_ctrl_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .adv      (adv),
    .cap      (cap),
    .addr     (req_addr),
    .wdata    (bus.mem_wdata),
    .ram_din  (bus.ram_din),
    .cnt      (cnt),
    .ram_a    (ram_a),
    .ram_dout (ram_dout),
    .rdata    (rdata)
  );

endmodule
